// File: rtl/sd_card_dat_phy_if.sv
// sd_card_dat_phy_if
//   Card-side block/FIFO handshake bundle of the SD card DAT PHY.
//   master : client logic (issues read requests, feeds the TX FIFO head,
//            receives words and status)
//   slave  : the PHY itself
//   Signals:
//     rd_start  request to send one read block (single-cycle)
//     tx_word   FIFO head, first-word-fall-through
//     tx_pop    consume tx_word at this edge
//     rx_word   received word, valid with rx_push
//     rx_push   one-cycle strobe per received word
//     done      one-cycle pulse at end of a block transaction
//     crc_err   sticky CRC / end-bit error of the last write block
//     idle      PHY is in IDLE
interface sd_card_dat_phy_if;
    logic        rd_start;
    logic [31:0] tx_word;
    logic        tx_pop;
    logic [31:0] rx_word;
    logic        rx_push;
    logic        done;
    logic        crc_err;
    logic        idle;

    modport master (
        output rd_start, tx_word,
        input  tx_pop, rx_word, rx_push, done, crc_err, idle
    );

    modport slave (
        input  rd_start, tx_word,
        output tx_pop, rx_word, rx_push, done, crc_err, idle
    );
endinterface

// File: rtl/sd_card_dat_phy.sv
// sd_card_dat_phy
//   Card-side single-bit DAT PHY. Receives host write blocks (start bit,
//   32*WORDS data bits MSB first, CRC16, end bit), answers with a CRC
//   status token and a busy period, and pushes words out. On rd_start it
//   sends a read block popped from a FIFO, framed start/data/CRC16/end.
//   Macro SD_CARD_DAT_CRC_EN: when defined, CRC16-CCITT is generated on TX
//   and checked on RX; when undefined no CRC logic exists, TX sends 16 zero
//   bits and RX only flags a 0 end bit.
//   Ports:
//     SDclock  clock, rising edge
//     reset    synchronous, active-high
//     dat_in   DAT line as seen by the card
//     dat_out  DAT value driven by the card (valid while dat_oe=1)
//     dat_oe   card pad output enable
//     bus      block/FIFO handshake (slave modport)
module sd_card_dat_phy #(
    parameter int WORDS       = 4,
    parameter int BUSY_CYCLES = 8
) (
    input  logic             SDclock,
    input  logic             reset,
    input  logic             dat_in,
    output logic             dat_out,
    output logic             dat_oe,
    sd_card_dat_phy_if.slave bus
);
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [3:0] {
        IDLE, RX_DATA, RX_CRC, RX_END, TOK_WAIT, TOK, BUSY,
        TX_START, TX_DATA, TX_CRC, TX_END
    } state_t;

    state_t          state, state_nx;
    logic [4:0]      bit_cnt;
    logic [WW-1:0]   word_cnt;
    logic [7:0]      busy_cnt;
    logic [30:0]     rx_sr;      // bit 31 of a word is never needed after capture
    logic [31:0]     tx_sr;
    logic            blk_bad;
    logic            last_bit, last_word, busy_last, rx_bad, crc_bit;

    assign last_bit  = (bit_cnt == 5'd31);
    assign last_word = (word_cnt == WW'(WORDS - 1));
    assign busy_last = (busy_cnt == 8'(BUSY_CYCLES));

`ifdef SD_CARD_DAT_CRC_EN
    logic [15:0] crc, crc_rx;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // crc accumulates over data bits only; on TX it is then shifted out
    always_ff @(posedge SDclock) begin
        if (reset) begin
            crc    <= '0;
            crc_rx <= '0;
        end else begin
            case (state)
                IDLE:    crc    <= '0;
                RX_DATA: crc    <= crc_step(crc, dat_in);
                RX_CRC:  crc_rx <= {crc_rx[14:0], dat_in};
                TX_DATA: crc    <= crc_step(crc, tx_sr[31]);
                TX_CRC:  crc    <= {crc[14:0], 1'b0};
                default: ;
            endcase
        end
    end

    assign rx_bad  = !dat_in || (crc_rx != crc);
    assign crc_bit = crc[15];
`else
    assign rx_bad  = !dat_in;
    assign crc_bit = 1'b0;
`endif

    always_ff @(posedge SDclock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        dat_out     = 1'b1;
        dat_oe      = 1'b0;
        bus.tx_pop  = 1'b0;
        bus.idle    = (state == IDLE);
        case (state)
            IDLE: begin
                // a start bit on the line beats a read request
                if (!dat_in)           state_nx = RX_DATA;
                else if (bus.rd_start) state_nx = TX_START;
            end
            RX_DATA:  if (last_bit && last_word) state_nx = RX_CRC;
            RX_CRC:   if (bit_cnt == 5'd15) state_nx = RX_END;
            RX_END:   state_nx = TOK_WAIT;
            TOK_WAIT: if (bit_cnt == 5'd1) state_nx = TOK;
            TOK: begin
                dat_oe = 1'b1;
                // token: 0, s2, s1, s0, 1 with status 010 good / 101 bad
                case (bit_cnt)
                    5'd0:    dat_out = 1'b0;
                    5'd1:    dat_out = blk_bad;
                    5'd2:    dat_out = !blk_bad;
                    5'd3:    dat_out = blk_bad;
                    default: dat_out = 1'b1;
                endcase
                if (bit_cnt == 5'd4) state_nx = blk_bad ? IDLE : BUSY;
            end
            BUSY: begin
                dat_oe  = 1'b1;
                dat_out = busy_last;
                if (busy_last) state_nx = IDLE;
            end
            TX_START: begin
                dat_oe     = 1'b1;
                dat_out    = 1'b0;
                bus.tx_pop = 1'b1;
                state_nx   = TX_DATA;
            end
            TX_DATA: begin
                dat_oe  = 1'b1;
                dat_out = tx_sr[31];
                if (last_bit) begin
                    if (last_word) state_nx   = TX_CRC;
                    else           bus.tx_pop = 1'b1;
                end
            end
            TX_CRC: begin
                dat_oe  = 1'b1;
                dat_out = crc_bit;
                if (bit_cnt == 5'd15) state_nx = TX_END;
            end
            TX_END: begin
                dat_oe   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge SDclock) begin
        if (reset) begin
            bit_cnt     <= '0;
            word_cnt    <= '0;
            busy_cnt    <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            blk_bad     <= 1'b0;
            bus.rx_word <= '0;
            bus.rx_push <= 1'b0;
            bus.done    <= 1'b0;
            bus.crc_err <= 1'b0;
        end else begin
            bus.rx_push <= 1'b0;
            bus.done    <= 1'b0;
            // bit counter restarts on every state change
            bit_cnt     <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    busy_cnt <= '0;
                    if (state_nx != IDLE) bus.crc_err <= 1'b0;
                end
                RX_DATA: begin
                    rx_sr <= {rx_sr[29:0], dat_in};
                    if (last_bit) begin
                        bus.rx_word <= {rx_sr, dat_in};
                        bus.rx_push <= 1'b1;
                        word_cnt    <= word_cnt + 1'b1;
                    end
                end
                RX_END: begin
                    blk_bad <= rx_bad;
                    if (rx_bad) bus.crc_err <= 1'b1;
                end
                TOK:  if (bit_cnt == 5'd4 && blk_bad) bus.done <= 1'b1;
                BUSY: begin
                    busy_cnt <= busy_cnt + 8'd1;
                    if (busy_last) bus.done <= 1'b1;
                end
                TX_START: tx_sr <= bus.tx_word;
                TX_DATA: begin
                    if (last_bit && !last_word) begin
                        tx_sr    <= bus.tx_word;
                        word_cnt <= word_cnt + 1'b1;
                    end else begin
                        tx_sr <= {tx_sr[30:0], 1'b0};
                    end
                end
                TX_END: bus.done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_card_dat_phy.sv
// tb_sd_card_dat_phy
//   Directed bench for sd_card_dat_phy (WORDS=4, BUSY_CYCLES=8): reset
//   values, good/bad write blocks, RX/TX collision, read blocks with CRC16,
//   reset in the middle of a read. Expected CRC follows SD_CARD_DAT_CRC_EN.
module tb_sd_card_dat_phy;
    localparam int WORDS = 4;
    localparam int BUSY  = 8;
`ifdef SD_CARD_DAT_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic SDclock = 1'b0;
    logic reset   = 1'b1;
    logic dat_in  = 1'b1;
    logic dat_out, dat_oe;

    sd_card_dat_phy_if bus ();

    sd_card_dat_phy #(.WORDS(WORDS), .BUSY_CYCLES(BUSY)) dut (
        .SDclock (SDclock),
        .reset   (reset),
        .dat_in  (dat_in),
        .dat_out (dat_out),
        .dat_oe  (dat_oe),
        .bus     (bus)
    );

    always #5 SDclock = ~SDclock;

    logic [31:0] fifo [16];
    logic [31:0] blk  [4];
    int fidx = 0;
    int pops = 0;
    int vectors = 0;
    int miscompares = 0;

    assign bus.tx_word = fifo[fidx];

    always @(posedge SDclock) begin
        if (bus.tx_pop) begin
            fidx <= fidx + 1;
            pops <= pops + 1;
        end
    end

    task automatic step();
        @(posedge SDclock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [31:0] w0, w1, w2, w3);
        logic [15:0]  c;
        logic [127:0] d;
        c = 16'h0000;
        d = {w0, w1, w2, w3};
        for (int i = 127; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    // Host write of blk[], followed by token / busy / done checks.
    task automatic host_write(input logic [15:0] crc_f, input logic endb,
                              input logic exp_bad, input logic with_rd);
        int p0;
        logic [4:0] tok;
        int nbusy;
        p0 = pops;
        dat_in = 1'b0;
        bus.rd_start = with_rd;
        step();
        bus.rd_start = 1'b0;
        check("wr_start_crc_err_clear", bus.crc_err, 0);
        check("wr_start_not_idle", bus.idle, 0);
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 31; b >= 0; b--) begin
                dat_in = blk[w][b];
                step();
                if (b == 16) check("wr_no_push_midword", bus.rx_push, 0);
                if (b == 0) begin
                    check("wr_rx_push", bus.rx_push, 1);
                    check("wr_rx_word", bus.rx_word, blk[w]);
                end
            end
        end
        for (int i = 15; i >= 0; i--) begin
            dat_in = crc_f[i];
            step();
        end
        dat_in = endb;
        step();
        dat_in = 1'b1;
        check("tokwait1_oe", dat_oe, 0);
        step();
        check("tokwait2_oe", dat_oe, 0);
        tok = exp_bad ? 5'b01011 : 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            step();
            check("tok_oe", dat_oe, 1);
            check("tok_bit", dat_out, tok[i]);
        end
        nbusy = exp_bad ? 0 : BUSY + 1;
        for (int i = 0; i < nbusy; i++) begin
            step();
            check("busy_oe", dat_oe, 1);
            check("busy_level", dat_out, (i == BUSY) ? 1 : 0);
        end
        step();
        check("wr_done", bus.done, 1);
        check("wr_end_oe", dat_oe, 0);
        check("wr_crc_err", bus.crc_err, exp_bad);
        check("wr_no_pop", pops - p0, 0);
        step();
        check("wr_done_one_cycle", bus.done, 0);
    endtask

    // Read block from fifo[base..base+3]; fidx must equal base.
    task automatic tx_read(input int base);
        int p0;
        logic [15:0] exp_crc;
        p0 = pops;
        exp_crc = CRC_ON ? crc_of(fifo[base], fifo[base+1], fifo[base+2], fifo[base+3]) : 16'h0000;
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        check("rd_start_oe", dat_oe, 1);
        check("rd_start_bit", dat_out, 0);
        check("rd_start_pop", bus.tx_pop, 1);
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 31; b >= 0; b--) begin
                step();
                check("rd_data_oe", dat_oe, 1);
                check("rd_data_bit", dat_out, fifo[base+w][b]);
            end
        end
        for (int i = 15; i >= 0; i--) begin
            step();
            check("rd_crc_bit", dat_out, exp_crc[i]);
        end
        step();
        check("rd_end_bit", dat_out, 1);
        check("rd_end_oe", dat_oe, 1);
        step();
        check("rd_done", bus.done, 1);
        check("rd_release_oe", dat_oe, 0);
        check("rd_idle", bus.idle, 1);
        check("rd_pop_count", pops - p0, WORDS);
    endtask

    initial begin
        int p0;
        bus.rd_start = 1'b0;
        for (int i = 0; i < 16; i++) fifo[i] = 32'h0;

        // reset values after the first edge with reset=1
        step();
        check("rst_dat_out", dat_out, 1);
        check("rst_dat_oe", dat_oe, 0);
        check("rst_tx_pop", bus.tx_pop, 0);
        check("rst_rx_push", bus.rx_push, 0);
        check("rst_rx_word", bus.rx_word, 0);
        check("rst_done", bus.done, 0);
        check("rst_crc_err", bus.crc_err, 0);
        check("rst_idle", bus.idle, 1);
        step();
        reset = 1'b0;
        step();

        // good all-zero write, CRC 0x0000
        for (int i = 0; i < 4; i++) blk[i] = 32'h0;
        host_write(16'h0000, 1'b1, 1'b0, 1'b0);

        // A5 pattern with CRC bit 0 flipped: bad only when CRC is checked
        for (int i = 0; i < 4; i++) blk[i] = 32'hA5A5A5A5;
        host_write(crc_of(blk[0], blk[1], blk[2], blk[3]) ^ 16'h0001, 1'b1, CRC_ON, 1'b0);
        repeat (3) step();
        check("crc_err_sticky", bus.crc_err, CRC_ON);

        // start bit and rd_start together: RX wins, read request dropped
        blk[0] = 32'h0F0F0F0F; blk[1] = 32'hF0F0F0F0;
        blk[2] = 32'h00FF00FF; blk[3] = 32'h13579BDF;
        host_write(crc_of(blk[0], blk[1], blk[2], blk[3]), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("collision_rd_dropped", dat_oe, 0);
        end

        // read block
        fifo[0] = 32'h12345678; fifo[1] = 32'h9ABCDEF0;
        fifo[2] = 32'h00000000; fifo[3] = 32'hFFFFFFFF;
        tx_read(0);

        // reset during data bit 40 of a read
        fifo[4] = 32'h11111111; fifo[5] = 32'h22222222;
        p0 = pops;
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        repeat (41) step();
        check("abort_driving_before_reset", dat_oe, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_oe", dat_oe, 0);
        check("abort_idle", bus.idle, 1);
        check("abort_no_done", bus.done, 0);
        check("abort_no_pop", bus.tx_pop, 0);
        step();
        check("abort_no_done_later", bus.done, 0);
        check("abort_pop_count", pops - p0, 2);

        // a following read is complete
        fifo[6] = 32'hDEADBEEF; fifo[7] = 32'h00000001;
        fifo[8] = 32'h80000000; fifo[9] = 32'hC3C3C3C3;
        tx_read(6);

        // end bit 0: bad regardless of CRC
        blk[0] = 32'hCAFEF00D; blk[1] = 32'h01234567;
        blk[2] = 32'h89ABCDEF; blk[3] = 32'h55AA55AA;
        host_write(crc_of(blk[0], blk[1], blk[2], blk[3]), 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
